sap_1_controller_sequencer: RTL and testbench



---
 rtl/sap_1_controller_sequencer_pkg.sv | 57 +++++
 rtl/sap_1_controller_sequencer_if.sv | 30 +++
 rtl/sap_1_ring_counter.sv | 25 ++
 rtl/sap_1_controller_sequencer.sv | 86 ++++++++
 tb/tb_sap_1_controller_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sap_1_controller_sequencer_pkg.sv
// Shared SAP-1 controller constants: opcode map, ring states and control-word layout.
// Control word bit order, MSB first: Cp Ep LMbar CEbar LIbar EIbar LAbar EA Su EU LBbar LObar.
package sap_1_controller_sequencer_pkg;

  localparam logic [3:0] OpLda = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpOut = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Bit 6 is the halt flag; the low six bits are the ring and read zero while halted.
  typedef enum logic [6:0] {
    StT1   = 7'b000_0001,
    StT2   = 7'b000_0010,
    StT3   = 7'b000_0100,
    StT4   = 7'b000_1000,
    StT5   = 7'b001_0000,
    StT6   = 7'b010_0000,
    StHalt = 7'b100_0000
  } state_e;

  localparam int unsigned CwCp    = 11;
  localparam int unsigned CwEp    = 10;
  localparam int unsigned CwLMbar = 9;
  localparam int unsigned CwCEbar = 8;
  localparam int unsigned CwLIbar = 7;
  localparam int unsigned CwEIbar = 6;
  localparam int unsigned CwLAbar = 5;
  localparam int unsigned CwEA    = 4;
  localparam int unsigned CwSu    = 3;
  localparam int unsigned CwEU    = 2;
  localparam int unsigned CwLBbar = 1;
  localparam int unsigned CwLObar = 0;

  localparam logic [11:0] CwIdle = 12'b0011_1110_0011;

  function automatic state_e ring_next(input state_e s);
    case (s)
      StT1:    return StT2;
      StT2:    return StT3;
      StT3:    return StT4;
      StT4:    return StT5;
      StT5:    return StT6;
      StT6:    return StT1;
      StHalt:  return StHalt;
      default: return StT1;
    endcase
  endfunction

endpackage

// File: rtl/sap_1_controller_sequencer_if.sv
// Opcode in, control word and ring state out, between SAP-1 controller and datapath.
interface sap_1_controller_sequencer_if;
  logic [3:0] opcode;
  logic       Cp;
  logic       Ep;
  logic       LMbar;
  logic       CEbar;
  logic       LIbar;
  logic       EIbar;
  logic       LAbar;
  logic       EA;
  logic       Su;
  logic       EU;
  logic       LBbar;
  logic       LObar;
  logic       HLTbar;
  logic [5:0] t_state;

  modport master (
    input  opcode,
    output Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, Su, EU, LBbar, LObar, HLTbar,
    output t_state
  );

  modport slave (
    output opcode,
    input  Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, Su, EU, LBbar, LObar, HLTbar,
    input  t_state
  );
endinterface

// File: rtl/sap_1_ring_counter.sv
// Six-state one-hot T-ring with an absorbing halt state, cleared synchronously by CLRbar.
module sap_1_ring_counter
  import sap_1_controller_sequencer_pkg::*;
(
  input  logic       Clk,
  input  logic       CLRbar,
  input  logic       halt_req,
  output logic [5:0] t_state
);

  state_e state_q;

  always_ff @(posedge Clk) begin
    if (!CLRbar) begin
      state_q <= StT1;
    end else if (halt_req && (state_q == StT4)) begin
      state_q <= StHalt;
    end else begin
      state_q <= ring_next(state_q);
    end
  end

  assign t_state = state_q[5:0];

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: T-ring plus opcode decode into the 12-bit control word.
module sap_1_controller_sequencer
  import sap_1_controller_sequencer_pkg::*;
(
  input  logic                          Clk,
  input  logic                          CLRbar,
  sap_1_controller_sequencer_if.master  cs
);

  logic [5:0]  t_state;
  logic        halt_req;
  logic [11:0] cw;
  logic        hlt_n;

  assign halt_req = (t_state == T4) && (cs.opcode == OpHlt);

  sap_1_ring_counter u_ring (
    .Clk      (Clk),
    .CLRbar   (CLRbar),
    .halt_req (halt_req),
    .t_state  (t_state)
  );

  // Opcode is only decoded in T4..T6, so T1..T3 produce the fetch word regardless.
  always_comb begin
    cw    = CwIdle;
    hlt_n = 1'b1;
    case (t_state)
      T1: begin
        cw[CwEp]    = 1'b1;
        cw[CwLMbar] = 1'b0;
      end
      T2: cw[CwCp] = 1'b1;
      T3: begin
        cw[CwCEbar] = 1'b0;
        cw[CwLIbar] = 1'b0;
      end
      T4: begin
        if (cs.opcode == OpLda || cs.opcode == OpAdd || cs.opcode == OpSub) begin
          cw[CwEIbar] = 1'b0;
          cw[CwLMbar] = 1'b0;
        end else if (cs.opcode == OpOut) begin
          cw[CwEA]    = 1'b1;
          cw[CwLObar] = 1'b0;
        end else if (cs.opcode == OpHlt) begin
          hlt_n = 1'b0;
        end
      end
      T5: begin
        if (cs.opcode == OpLda) begin
          cw[CwCEbar] = 1'b0;
          cw[CwLAbar] = 1'b0;
        end else if (cs.opcode == OpAdd || cs.opcode == OpSub) begin
          cw[CwCEbar] = 1'b0;
          cw[CwLBbar] = 1'b0;
        end
      end
      T6: begin
        if (cs.opcode == OpAdd || cs.opcode == OpSub) begin
          cw[CwEU]    = 1'b1;
          cw[CwLAbar] = 1'b0;
        end
      end
      default: hlt_n = 1'b0;
    endcase
    if ((t_state == T4 || t_state == T5 || t_state == T6) && cs.opcode == OpSub) begin
      cw[CwSu] = 1'b1;
    end
  end

  assign cs.Cp      = cw[CwCp];
  assign cs.Ep      = cw[CwEp];
  assign cs.LMbar   = cw[CwLMbar];
  assign cs.CEbar   = cw[CwCEbar];
  assign cs.LIbar   = cw[CwLIbar];
  assign cs.EIbar   = cw[CwEIbar];
  assign cs.LAbar   = cw[CwLAbar];
  assign cs.EA      = cw[CwEA];
  assign cs.Su      = cw[CwSu];
  assign cs.EU      = cw[CwEU];
  assign cs.LBbar   = cw[CwLBbar];
  assign cs.LObar   = cw[CwLObar];
  assign cs.HLTbar  = hlt_n;
  assign cs.t_state = t_state;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Self-checking bench: a cycle model pushes expected words, sampled DUT words are popped and compared.
module tb_sap_1_controller_sequencer;

  typedef struct {
    logic [5:0]  t;
    logic [11:0] cw;
    logic        hlt;
  } rec_t;

  logic clk;
  logic clr_n;
  int   n_assert;
  int   n_fail;
  int   ph;
  rec_t exp_q[$];
  rec_t obs_q[$];

  sap_1_controller_sequencer_if dut_if ();

  sap_1_controller_sequencer dut (
    .Clk    (clk),
    .CLRbar (clr_n),
    .cs     (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word, bit order Cp Ep LMbar CEbar LIbar EIbar LAbar EA Su EU LBbar LObar.
  function automatic logic [11:0] exp_cw(input int p, input logic [3:0] op);
    logic [11:0] w;
    w = 12'b0011_1110_0011;
    case (p)
      1: w = 12'b0101_1110_0011;
      2: w = 12'b1011_1110_0011;
      3: w = 12'b0010_0110_0011;
      4: begin
        if (op == 4'b0000 || op == 4'b0001) w = 12'b0001_1010_0011;
        if (op == 4'b0010)                  w = 12'b0001_1010_1011;
        if (op == 4'b1110)                  w = 12'b0011_1111_0010;
      end
      5: begin
        if (op == 4'b0000) w = 12'b0010_1100_0011;
        if (op == 4'b0001) w = 12'b0010_1110_0001;
        if (op == 4'b0010) w = 12'b0010_1110_1001;
      end
      6: begin
        if (op == 4'b0001) w = 12'b0011_1100_0111;
        if (op == 4'b0010) w = 12'b0011_1100_1111;
      end
      default: w = 12'b0011_1110_0011;
    endcase
    return w;
  endfunction

  task automatic drive_cycle(input logic [3:0] op, input logic clr);
    rec_t e;
    rec_t o;
    dut_if.opcode = op;
    clr_n = clr;
    e.t   = (ph == 0) ? 6'b000000 : 6'(1 << (ph - 1));
    e.cw  = exp_cw(ph, op);
    e.hlt = !((ph == 0) || (ph == 4 && op == 4'b1111));
    exp_q.push_back(e);
    @(negedge clk);
    o.t   = dut_if.t_state;
    o.cw  = {dut_if.Cp, dut_if.Ep, dut_if.LMbar, dut_if.CEbar, dut_if.LIbar, dut_if.EIbar,
             dut_if.LAbar, dut_if.EA, dut_if.Su, dut_if.EU, dut_if.LBbar, dut_if.LObar};
    o.hlt = dut_if.HLTbar;
    obs_q.push_back(o);
    if (!clr)                     ph = 1;
    else if (ph == 0)             ph = 0;
    else if (ph == 4 && op == 4'b1111) ph = 0;
    else                          ph = (ph == 6) ? 1 : ph + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) drive_cycle(op, 1'b1);
  endtask

  task automatic test_reset;
    rec_t e, o;
    drive_cycle(4'b0001, 1'b0);
    drive_cycle(4'b0010, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert += 3;
      if (o.t !== e.t)   begin n_fail++; $display("FAIL reset t_state got %b exp %b", o.t, e.t); end
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL reset cw got %b exp %b", o.cw, e.cw); end
      if (o.hlt !== e.hlt) begin n_fail++; $display("FAIL reset HLTbar got %b exp %b", o.hlt, e.hlt); end
    end
  endtask

  task automatic test_lda;
    rec_t e, o;
    run_instr(4'b0000);
    drive_cycle(4'b0000, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert += 3;
      if (o.t !== e.t)   begin n_fail++; $display("FAIL lda t_state got %b exp %b", o.t, e.t); end
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL lda cw got %b exp %b", o.cw, e.cw); end
      if (o.hlt !== e.hlt) begin n_fail++; $display("FAIL lda HLTbar got %b exp %b", o.hlt, e.hlt); end
    end
    // Finish the instruction whose T1 was just observed.
    for (int i = 0; i < 5; i++) drive_cycle(4'b0000, 1'b1);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    rec_t e, o;
    run_instr(4'b0001);
    run_instr(4'b0010);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert += 3;
      if (o.t !== e.t)   begin n_fail++; $display("FAIL addsub t_state got %b exp %b", o.t, e.t); end
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL addsub cw got %b exp %b", o.cw, e.cw); end
      if (o.hlt !== e.hlt) begin n_fail++; $display("FAIL addsub HLTbar got %b exp %b", o.hlt, e.hlt); end
    end
  endtask

  task automatic test_out;
    rec_t e, o;
    int drv;
    run_instr(4'b1110);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      drv = int'(o.cw[10]) + int'(!o.cw[8]) + int'(!o.cw[6]) + int'(o.cw[4]) + int'(o.cw[2]);
      n_assert += 3;
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL out cw got %b exp %b", o.cw, e.cw); end
      if (o.t !== e.t)   begin n_fail++; $display("FAIL out t_state got %b exp %b", o.t, e.t); end
      if (drv > 1)       begin n_fail++; $display("FAIL out bus drivers got %0d exp <=1", drv); end
    end
  endtask

  task automatic test_halt;
    rec_t e, o;
    run_instr(4'b1111);
    for (int i = 0; i < 8; i++) drive_cycle(4'($urandom_range(0, 15)), 1'b1);
    drive_cycle(4'b1111, 1'b0);
    drive_cycle(4'b1111, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert += 3;
      if (o.t !== e.t)   begin n_fail++; $display("FAIL halt t_state got %b exp %b", o.t, e.t); end
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL halt cw got %b exp %b", o.cw, e.cw); end
      if (o.hlt !== e.hlt) begin n_fail++; $display("FAIL halt HLTbar got %b exp %b", o.hlt, e.hlt); end
    end
    for (int i = 0; i < 4; i++) drive_cycle(4'b0000, 1'b1);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid;
    rec_t e, o;
    for (int i = 0; i < 4; i++) drive_cycle(4'b0001, 1'b1);
    drive_cycle(4'b0001, 1'b0);
    for (int i = 0; i < 6; i++) drive_cycle(4'b0001, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert += 3;
      if (o.t !== e.t)   begin n_fail++; $display("FAIL rstmid t_state got %b exp %b", o.t, e.t); end
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL rstmid cw got %b exp %b", o.cw, e.cw); end
      if (o.hlt !== e.hlt) begin n_fail++; $display("FAIL rstmid HLTbar got %b exp %b", o.hlt, e.hlt); end
    end
  endtask

  task automatic test_nop;
    rec_t e, o;
    run_instr(4'b0111);
    drive_cycle(4'b0111, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert += 2;
      if (o.t !== e.t)   begin n_fail++; $display("FAIL nop t_state got %b exp %b", o.t, e.t); end
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL nop cw got %b exp %b", o.cw, e.cw); end
    end
    for (int i = 0; i < 5; i++) drive_cycle(4'b0111, 1'b1);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random;
    rec_t e, o;
    int drv;
    for (int i = 0; i < 1000; i++) drive_cycle(4'($urandom_range(0, 15)), (ph == 0) ? 1'b0 : 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      drv = int'(o.cw[10]) + int'(!o.cw[8]) + int'(!o.cw[6]) + int'(o.cw[4]) + int'(o.cw[2]);
      n_assert += 3;
      if (drv > 1)       begin n_fail++; $display("FAIL rand bus drivers got %0d exp <=1", drv); end
      if (o.cw !== e.cw) begin n_fail++; $display("FAIL rand cw got %b exp %b", o.cw, e.cw); end
      if (o.t !== e.t)   begin n_fail++; $display("FAIL rand t_state got %b exp %b", o.t, e.t); end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    dut_if.opcode = 4'b0000;
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    ph = 1;
    test_reset();
    test_lda();
    test_back_to_back();
    test_out();
    test_halt();
    test_reset_mid();
    test_nop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
